des_key_schedule: RTL and testbench
===================================

Name: des_key_schedule

Overview:
Sequential DES key-schedule generator that sits directly downstream of the PC1 permutation stage. It loads the 56-bit PC1 output (C0||D0) and emits the 16 round subkeys K1..K16 one at a time over a valid/ready handshake. Subkeys come out in forward order for encryption and reverse order for decryption. It feeds the round-function datapath.

Parameters:
NUM_ROUNDS, 16, subkeys per schedule; fixed by DES, no other value is supported.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request a new schedule; honoured only in IDLE
decrypt  input  1  sampled with start; 1 = emit K16..K1
pc1_key  input  56  PC1 output: [55:28] = C0, [27:0] = D0 (bit 55 = C bit 1)
subkey  output  48  current round subkey, PC2(C,D); [47] = PC2 output bit 1
subkey_valid  output  1  subkey and round_idx are valid
subkey_ready  input  1  consumer accepts subkey this cycle
round_idx  output  4  FIPS round number of subkey minus 1 (0..15)
busy  output  1  schedule in progress (state RUN)
done  output  1  one-cycle pulse after the last subkey is accepted

Behaviour:
- Reset (async, rst_n=0): state=IDLE, C=D=0, cnt=0, dec=0, subkey_valid=0, busy=0, done=0, round_idx=0. subkey is then PC2(0,0)=0.
- Shift table SH[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (sum 28). Rotate-left moves toward the MSB: C <= {C[26:0],C[27]} for 1, {C[25:0],C[27:26]} for 2. Right rotate is the mirror. D is treated identically.
- Two states, IDLE and RUN. cnt is 4 bits and counts accepted subkeys.
- IDLE, start=1 at edge N: dec <= decrypt, cnt <= 0, state <= RUN.
  - Encrypt: C,D <= rotl(C0,D0,1), which is C1,D1.
  - Decrypt: C,D <= C0,D0. This equals C16,D16 because the shifts total 28.
- RUN: subkey_valid=1 and busy=1. First subkey is visible after edge N, so latency is 1 cycle.
- round_idx = cnt for encrypt, 15-cnt for decrypt.
- subkey = PC2(C,D), combinational from the C/D registers. It holds stable while valid and not ready.
- valid & ready with cnt<15: cnt++.
  - Encrypt: rotl by SH[cnt+2].
  - Decrypt: rotr by SH[16-cnt], undoing the shift of the round just emitted.
- valid & ready with cnt==15: state <= IDLE, subkey_valid <= 0, done <= 1 for exactly one cycle. C/D are not rotated further.
- start while RUN: ignored. pc1_key and decrypt are not sampled.
- start in the same cycle as the final handshake: ignored, because state is still RUN. A new start is accepted from the following cycle, and may coincide with the done pulse.
- subkey_ready while not valid: no effect.
- Back-to-back throughput: with ready held high, all 16 subkeys arrive on 16 consecutive cycles.
- rst_n asserted mid-schedule: immediate return to the reset values. No done pulse.
- pc1_key is only sampled at the start edge. Later changes have no effect.

Decomposition:
- Shared package des_pkg:
  - SH shift table as a 16-entry constant.
  - PC2 index table as a 48-entry constant.
  - Width constants: KEY56_W=56, HALF_W=28, SUBKEY_W=48, ROUND_W=4.
  - State enum {IDLE, RUN}.
- Sub-module des_pc2: combinational 56->48 PC2 permutation, instantiated once on {C,D}.
- The rotator stays inline as a function in the package.

Test Plan:
- Encrypt, pc1_key=56'hF0CCAAF556678F, start, ready=1 -> next cycle valid, round_idx=0, subkey=48'h1B02EFFC7072. Valid on 16 consecutive cycles; last subkey=48'hCB3D8B0E17F5 with round_idx=15; then valid=0 and a single done pulse.
- Same key, decrypt=1 -> first subkey=48'hCB3D8B0E17F5 (round_idx=15), last=48'h1B02EFFC7072 (round_idx=0). The sequence is the exact reverse of the encrypt run, checked against the reference model.
- Backpressure: ready toggles pseudo-randomly -> subkey and round_idx hold while ready=0. No subkey is skipped or repeated, and done fires only after the 16th accept.
- start pulsed with a different pc1_key at round 7, and again with the final accept -> both ignored, sequence unchanged. start on the done cycle -> new schedule accepted, first subkey next cycle.
- rst_n low asynchronously at round 9 -> valid, busy and done go 0 immediately without a clock. After release, a fresh start yields the correct K1.
- Random keys (1000 runs, both modes) -> every subkey matches a software DES key schedule.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: widths, per-round shift counts, PC2 table,
// FSM states and the 28-bit half-key rotator.
package des_pkg;

    localparam int KEY56_W    = 56;
    localparam int HALF_W     = 28;
    localparam int SUBKEY_W   = 48;
    localparam int ROUND_W    = 4;
    localparam int NUM_ROUNDS = 16;

    // SH[r-1] is the left-rotate amount applied to produce C_r/D_r.
    localparam logic [1:0] SH [NUM_ROUNDS] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // PC2 source bit (1-based, bit 1 = MSB of C||D) for each subkey bit 1..48.
    localparam int PC2_TBL [SUBKEY_W] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ks_state_t;

    // Left rotation moves bits toward the MSB; amount is 1 or 2.
    function automatic logic [HALF_W-1:0] rot28(input logic [HALF_W-1:0] v,
                                                input logic [1:0]        amt,
                                                input logic              left);
        logic [HALF_W-1:0] r;
        r = v;
        if (left) begin
            if (amt == 2'd2) r = {v[HALF_W-3:0], v[HALF_W-1:HALF_W-2]};
            else             r = {v[HALF_W-2:0], v[HALF_W-1]};
        end else begin
            if (amt == 2'd2) r = {v[1:0], v[HALF_W-1:2]};
            else             r = {v[0], v[HALF_W-1:1]};
        end
        return r;
    endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// Load/command and subkey-stream signals between PC1 stage, key schedule and round datapath.
interface des_key_schedule_if;
    import des_pkg::*;

    logic                start;
    logic                decrypt;
    logic [KEY56_W-1:0]  pc1_key;
    logic [SUBKEY_W-1:0] subkey;
    logic                subkey_valid;
    logic                subkey_ready;
    logic [ROUND_W-1:0]  round_idx;
    logic                busy;
    logic                done;

    modport master (
        output start, decrypt, pc1_key, subkey_ready,
        input  subkey, subkey_valid, round_idx, busy, done
    );

    modport slave (
        input  start, decrypt, pc1_key, subkey_ready,
        output subkey, subkey_valid, round_idx, busy, done
    );

endinterface

// File: rtl/des_pc2.sv
// DES PC2 compression permutation, 56 -> 48 bits.
// Latency: purely combinational.
// Backpressure: none, pure wiring.
module des_pc2
    import des_pkg::*;
(
    input  logic [KEY56_W-1:0]  cd,
    output logic [SUBKEY_W-1:0] k
);

    for (genvar j = 0; j < SUBKEY_W; j++) begin : g_bit
        assign k[SUBKEY_W-1-j] = cd[KEY56_W-PC2_TBL[j]];
    end

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: loads C0||D0, streams K1..K16 (or K16..K1 for decrypt).
// Latency: first subkey visible one cycle after start; then one subkey per accept.
// Backpressure: subkey/round_idx hold while subkey_valid && !subkey_ready.
module des_key_schedule
    import des_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    des_key_schedule_if.slave ks
);

    ks_state_t          state, state_nxt;
    logic [HALF_W-1:0]  c_q, d_q;
    logic [ROUND_W-1:0] cnt;
    logic               dec;
    logic               done_q;
    logic               accept;
    logic               last;
    logic [1:0]         step_amt;

    assign accept = (state == RUN) && ks.subkey_ready;
    assign last   = (cnt == 4'd15);

    // Encrypt steps forward to the next round's shift; decrypt undoes the
    // shift of the round that was just emitted.
    assign step_amt = dec ? SH[4'd15 - cnt] : SH[cnt + 4'd1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ks.start)      state_nxt = RUN;
            RUN:     if (accept && last) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ks.subkey_valid = (state == RUN);
        ks.busy         = (state == RUN);
        ks.round_idx    = dec ? (4'd15 - cnt) : cnt;
        ks.done         = done_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q    <= '0;
            d_q    <= '0;
            cnt    <= '0;
            dec    <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == IDLE && ks.start) begin
                dec <= ks.decrypt;
                cnt <= '0;
                // C0||D0 already equals C16||D16 since the shifts total 28.
                if (ks.decrypt) begin
                    c_q <= ks.pc1_key[KEY56_W-1:HALF_W];
                    d_q <= ks.pc1_key[HALF_W-1:0];
                end else begin
                    c_q <= rot28(ks.pc1_key[KEY56_W-1:HALF_W], 2'd1, 1'b1);
                    d_q <= rot28(ks.pc1_key[HALF_W-1:0], 2'd1, 1'b1);
                end
            end else if (accept) begin
                if (last) begin
                    done_q <= 1'b1;
                end else begin
                    cnt <= cnt + 4'd1;
                    c_q <= rot28(c_q, step_amt, ~dec);
                    d_q <= rot28(d_q, step_amt, ~dec);
                end
            end
        end
    end

    des_pc2 u_pc2 (
        .cd ({c_q, d_q}),
        .k  (ks.subkey)
    );

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed and randomised checks of the DES key schedule against a cumulative-shift reference.
module tb_des_key_schedule;

    localparam logic [55:0] KEY  = 56'hF0CCAAF556678F;
    localparam logic [55:0] KEY2 = 56'h123456789ABCDE;
    localparam logic [47:0] K1   = 48'h1B02EFFC7072;
    localparam logic [47:0] K16  = 48'hCB3D8B0E17F5;

    localparam int SHT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int PC2T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    logic [47:0] enc_seq [16];

    always #5 clk = ~clk;

    des_key_schedule_if ksif ();

    des_key_schedule dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ks    (ksif.slave)
    );

    // Reference: rotate C0/D0 by the total shift up to round r, then apply PC2.
    function automatic logic [47:0] ref_subkey(input logic [55:0] k, input int r);
        logic [27:0] c;
        logic [27:0] d;
        logic [55:0] cd;
        logic [47:0] o;
        int total;
        total = 0;
        for (int j = 0; j < r; j++) total += SHT[j];
        c = k[55:28];
        d = k[27:0];
        for (int n = 0; n < total; n++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        cd = {c, d};
        o = '0;
        for (int j = 0; j < 48; j++) o[47-j] = cd[56-PC2T[j]];
        return o;
    endfunction

    task automatic kick(input logic [55:0] k, input logic dec);
        ksif.pc1_key = k;
        ksif.decrypt = dec;
        ksif.start   = 1'b1;
        @(posedge clk); #1;
        ksif.start   = 1'b0;
        ksif.pc1_key = ~k;
        ksif.decrypt = ~dec;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ksif.start = 1'b0; ksif.decrypt = 1'b0; ksif.pc1_key = '0; ksif.subkey_ready = 1'b0;
        #23;
        checks++; if (ksif.subkey_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ksif.subkey_valid); end
        checks++; if (ksif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", ksif.busy); end
        checks++; if (ksif.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", ksif.done); end
        checks++; if (ksif.round_idx !== 4'd0) begin errors++; $display("FAIL reset_round got=%0d exp=0", ksif.round_idx); end
        checks++; if (ksif.subkey !== 48'h0) begin errors++; $display("FAIL reset_subkey got=%h exp=0", ksif.subkey); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_encrypt();
        ksif.subkey_ready = 1'b1;
        kick(KEY, 1'b0);
        for (int i = 0; i < 16; i++) begin
            enc_seq[i] = ksif.subkey;
            checks++; if (ksif.subkey_valid !== 1'b1) begin errors++; $display("FAIL enc_valid i=%0d got=%b exp=1", i, ksif.subkey_valid); end
            checks++; if (ksif.round_idx !== 4'(i)) begin errors++; $display("FAIL enc_round i=%0d got=%0d exp=%0d", i, ksif.round_idx, i); end
            checks++; if (ksif.subkey !== ref_subkey(KEY, i + 1)) begin errors++; $display("FAIL enc_subkey i=%0d got=%h exp=%h", i, ksif.subkey, ref_subkey(KEY, i + 1)); end
            checks++; if (ksif.done !== 1'b0) begin errors++; $display("FAIL enc_early_done i=%0d got=%b", i, ksif.done); end
            if (i == 0) begin
                checks++; if (ksif.subkey !== K1) begin errors++; $display("FAIL enc_k1 got=%h exp=%h", ksif.subkey, K1); end
            end
            if (i == 15) begin
                checks++; if (ksif.subkey !== K16) begin errors++; $display("FAIL enc_k16 got=%h exp=%h", ksif.subkey, K16); end
            end
            @(posedge clk); #1;
        end
        checks++; if (ksif.subkey_valid !== 1'b0) begin errors++; $display("FAIL enc_end_valid got=%b exp=0", ksif.subkey_valid); end
        checks++; if (ksif.done !== 1'b1) begin errors++; $display("FAIL enc_done got=%b exp=1", ksif.done); end
        checks++; if (ksif.busy !== 1'b0) begin errors++; $display("FAIL enc_end_busy got=%b exp=0", ksif.busy); end
        @(posedge clk); #1;
        checks++; if (ksif.done !== 1'b0) begin errors++; $display("FAIL enc_done_pulse got=%b exp=0", ksif.done); end
    endtask

    task automatic test_decrypt();
        ksif.subkey_ready = 1'b1;
        kick(KEY, 1'b1);
        for (int i = 0; i < 16; i++) begin
            checks++; if (ksif.round_idx !== 4'(15 - i)) begin errors++; $display("FAIL dec_round i=%0d got=%0d exp=%0d", i, ksif.round_idx, 15 - i); end
            checks++; if (ksif.subkey !== ref_subkey(KEY, 16 - i)) begin errors++; $display("FAIL dec_subkey i=%0d got=%h exp=%h", i, ksif.subkey, ref_subkey(KEY, 16 - i)); end
            checks++; if (ksif.subkey !== enc_seq[15-i]) begin errors++; $display("FAIL dec_reverse i=%0d got=%h exp=%h", i, ksif.subkey, enc_seq[15-i]); end
            if (i == 0) begin
                checks++; if (ksif.subkey !== K16) begin errors++; $display("FAIL dec_first got=%h exp=%h", ksif.subkey, K16); end
            end
            if (i == 15) begin
                checks++; if (ksif.subkey !== K1) begin errors++; $display("FAIL dec_last got=%h exp=%h", ksif.subkey, K1); end
            end
            @(posedge clk); #1;
        end
        checks++; if (ksif.done !== 1'b1) begin errors++; $display("FAIL dec_done got=%b exp=1", ksif.done); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int accepted;
        int cyc;
        accepted = 0;
        cyc = 0;
        ksif.subkey_ready = 1'b0;
        kick(KEY2, 1'b0);
        while (accepted < 16 && cyc < 400) begin
            checks++; if (ksif.subkey_valid !== 1'b1 || ksif.round_idx !== 4'(accepted) || ksif.subkey !== ref_subkey(KEY2, accepted + 1) || ksif.done !== 1'b0)
                begin errors++; $display("FAIL bp_hold acc=%0d got v=%b r=%0d k=%h d=%b exp v=1 r=%0d k=%h d=0", accepted, ksif.subkey_valid, ksif.round_idx, ksif.subkey, ksif.done, accepted, ref_subkey(KEY2, accepted + 1)); end
            ksif.subkey_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (ksif.subkey_ready) accepted++;
            cyc++;
        end
        checks++; if (accepted != 16) begin errors++; $display("FAIL bp_timeout accepted=%0d exp=16", accepted); end
        checks++; if (ksif.subkey_valid !== 1'b0 || ksif.done !== 1'b1) begin errors++; $display("FAIL bp_end got v=%b d=%b exp v=0 d=1", ksif.subkey_valid, ksif.done); end
        ksif.subkey_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_start_ignored();
        ksif.subkey_ready = 1'b1;
        kick(KEY, 1'b0);
        for (int i = 0; i < 16; i++) begin
            checks++; if (ksif.subkey !== ref_subkey(KEY, i + 1) || ksif.round_idx !== 4'(i)) begin errors++; $display("FAIL ign_seq i=%0d got k=%h r=%0d exp k=%h r=%0d", i, ksif.subkey, ksif.round_idx, ref_subkey(KEY, i + 1), i); end
            ksif.start   = (i == 6 || i == 15);
            ksif.pc1_key = KEY2;
            ksif.decrypt = 1'b1;
            @(posedge clk); #1;
        end
        ksif.start = 1'b0;
        checks++; if (ksif.subkey_valid !== 1'b0 || ksif.done !== 1'b1) begin errors++; $display("FAIL ign_final_start got v=%b d=%b exp v=0 d=1", ksif.subkey_valid, ksif.done); end
        kick(KEY2, 1'b0);
        checks++; if (ksif.subkey_valid !== 1'b1 || ksif.round_idx !== 4'd0 || ksif.subkey !== ref_subkey(KEY2, 1)) begin errors++; $display("FAIL restart_on_done got v=%b r=%0d k=%h exp v=1 r=0 k=%h", ksif.subkey_valid, ksif.round_idx, ksif.subkey, ref_subkey(KEY2, 1)); end
        repeat (16) begin @(posedge clk); #1; end
        checks++; if (ksif.done !== 1'b1) begin errors++; $display("FAIL restart_done got=%b exp=1", ksif.done); end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        ksif.subkey_ready = 1'b1;
        kick(KEY, 1'b0);
        repeat (8) begin @(posedge clk); #1; end
        checks++; if (ksif.round_idx !== 4'd8) begin errors++; $display("FAIL ar_round got=%0d exp=8", ksif.round_idx); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (ksif.subkey_valid !== 1'b0 || ksif.busy !== 1'b0 || ksif.done !== 1'b0) begin errors++; $display("FAIL ar_immediate got v=%b b=%b d=%b exp 0 0 0", ksif.subkey_valid, ksif.busy, ksif.done); end
        checks++; if (ksif.round_idx !== 4'd0 || ksif.subkey !== 48'h0) begin errors++; $display("FAIL ar_regs got r=%0d k=%h exp r=0 k=0", ksif.round_idx, ksif.subkey); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if (ksif.done !== 1'b0) begin errors++; $display("FAIL ar_no_done got=%b exp=0", ksif.done); end
        kick(KEY, 1'b0);
        checks++; if (ksif.subkey !== K1 || ksif.round_idx !== 4'd0) begin errors++; $display("FAIL ar_fresh got k=%h r=%0d exp k=%h r=0", ksif.subkey, ksif.round_idx, K1); end
        repeat (16) begin @(posedge clk); #1; end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [63:0] raw;
        logic [55:0] k;
        logic        dec;
        int          r;
        ksif.subkey_ready = 1'b1;
        for (int run = 0; run < 1000; run++) begin
            raw = {$urandom, $urandom};
            k   = raw[55:0];
            dec = 1'(run % 2);
            kick(k, dec);
            for (int i = 0; i < 16; i++) begin
                r = dec ? 16 - i : i + 1;
                checks++; if (ksif.subkey_valid !== 1'b1 || ksif.subkey !== ref_subkey(k, r) || ksif.round_idx !== 4'(r - 1))
                    begin errors++; $display("FAIL rnd run=%0d i=%0d key=%h got v=%b k=%h r=%0d exp k=%h r=%0d", run, i, k, ksif.subkey_valid, ksif.subkey, ksif.round_idx, ref_subkey(k, r), r - 1); end
                @(posedge clk); #1;
            end
            checks++; if (ksif.done !== 1'b1) begin errors++; $display("FAIL rnd_done run=%0d got=%b exp=1", run, ksif.done); end
        end
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt();
        test_backpressure();
        test_start_ignored();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
